// File: rtl/qif_mon_pkg.sv
// Shared types and default widths for the QIF spike monitor.
`timescale 1ns/1ps
package qif_mon_pkg;

  localparam int unsigned QIF_MON_WINDOW_W = 16;
  localparam int unsigned QIF_MON_CNT_W    = 8;
  localparam int unsigned QIF_MON_ISI_W    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } qif_mon_state_t;

endpackage

// File: rtl/qif_spike_edge_detect.sv
// Rising-edge detector for a clk-synchronous spike line; spike_q follows the input
// unconditionally so a level that is already high never looks like an edge.
`timescale 1ns/1ps
module qif_spike_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_in,
  output logic spike_edge_c
);

  logic r_spike_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_spike_q <= 1'b0;
    else        r_spike_q <= spike_in;
  end

  assign spike_edge_c = spike_in & ~r_spike_q;

endmodule

// File: rtl/qif_spike_monitor.sv
// Windowed spike counter and inter-spike interval meter for the QIF neuron output.
// Define QIF_SPIKE_MON_ISI_EN to build the ISI logic; otherwise isi/isi_valid are tied low.
`timescale 1ns/1ps
module qif_spike_monitor
  import qif_mon_pkg::*;
#(
  parameter int unsigned WINDOW_W = QIF_MON_WINDOW_W,
  parameter int unsigned CNT_W    = QIF_MON_CNT_W,
  parameter int unsigned ISI_W    = QIF_MON_ISI_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                spike_in,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [CNT_W-1:0]    spike_count,
  output logic                count_valid,
  output logic                overflow,
  output logic [ISI_W-1:0]    isi,
  output logic                isi_valid
);

  qif_mon_state_t      r_state, w_state_nxt;
  logic [WINDOW_W-1:0] r_win_cnt, w_win_cnt_nxt;
  logic [CNT_W-1:0]    r_acc, w_acc_nxt, w_acc_inc;
  logic                r_ovf, w_ovf_nxt, w_ovf_inc;
  logic [CNT_W-1:0]    r_spike_count, w_spike_count_nxt;
  logic                r_count_valid, w_count_valid_nxt;
  logic                r_overflow, w_overflow_nxt;
  logic                w_edge;

  qif_spike_edge_detect u_edge (
    .clk          (clk),
    .rst_n        (rst_n),
    .spike_in     (spike_in),
    .spike_edge_c (w_edge)
  );

  // Saturating accumulate of this cycle's edge; the sticky flag catches edges lost at all-ones.
  assign w_acc_inc = (w_edge && (r_acc != '1)) ? r_acc + CNT_W'(1) : r_acc;
  assign w_ovf_inc = r_ovf | (w_edge & (r_acc == '1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_win_cnt     <= '0;
      r_acc         <= '0;
      r_ovf         <= 1'b0;
      r_spike_count <= '0;
      r_count_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_win_cnt     <= w_win_cnt_nxt;
      r_acc         <= w_acc_nxt;
      r_ovf         <= w_ovf_nxt;
      r_spike_count <= w_spike_count_nxt;
      r_count_valid <= w_count_valid_nxt;
      r_overflow    <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_win_cnt_nxt     = r_win_cnt;
    w_acc_nxt         = r_acc;
    w_ovf_nxt         = r_ovf;
    w_spike_count_nxt = r_spike_count;
    w_count_valid_nxt = 1'b0;
    w_overflow_nxt    = r_overflow;
    case (r_state)
      IDLE: begin
        if (enable && (window_len != '0)) begin
          w_state_nxt   = RUN;
          w_win_cnt_nxt = window_len - WINDOW_W'(1);
          w_acc_nxt     = '0;
          w_ovf_nxt     = 1'b0;
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (r_win_cnt == '0) begin
          // Last window cycle: publish, clear, and resample the length for the next window.
          w_spike_count_nxt = w_acc_inc;
          w_overflow_nxt    = w_ovf_inc;
          w_count_valid_nxt = 1'b1;
          w_acc_nxt         = '0;
          w_ovf_nxt         = 1'b0;
          if (window_len == '0) w_state_nxt = IDLE;
          else                  w_win_cnt_nxt = window_len - WINDOW_W'(1);
        end else begin
          w_win_cnt_nxt = r_win_cnt - WINDOW_W'(1);
          w_acc_nxt     = w_acc_inc;
          w_ovf_nxt     = w_ovf_inc;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign spike_count = r_spike_count;
  assign count_valid = r_count_valid;
  assign overflow    = r_overflow;

`ifdef QIF_SPIKE_MON_ISI_EN
  logic             w_run_act;
  logic             r_armed, w_armed_nxt;
  logic [ISI_W-1:0] r_ivl, w_ivl_nxt;
  logic [ISI_W-1:0] r_isi, w_isi_nxt;
  logic             r_isi_valid, w_isi_valid_nxt;

  assign w_run_act = (r_state == RUN) && enable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed     <= 1'b0;
      r_ivl       <= '0;
      r_isi       <= '0;
      r_isi_valid <= 1'b0;
    end else begin
      r_armed     <= w_armed_nxt;
      r_ivl       <= w_ivl_nxt;
      r_isi       <= w_isi_nxt;
      r_isi_valid <= w_isi_valid_nxt;
    end
  end

  // First edge of a run only arms; the interval counter saturates so long gaps read all-ones.
  always_comb begin
    w_armed_nxt     = r_armed;
    w_ivl_nxt       = r_ivl;
    w_isi_nxt       = r_isi;
    w_isi_valid_nxt = 1'b0;
    if (!w_run_act) begin
      w_armed_nxt = 1'b0;
    end else if (w_edge) begin
      if (r_armed) begin
        w_isi_nxt       = r_ivl;
        w_isi_valid_nxt = 1'b1;
      end
      w_ivl_nxt   = ISI_W'(1);
      w_armed_nxt = 1'b1;
    end else if (r_ivl != '1) begin
      w_ivl_nxt = r_ivl + ISI_W'(1);
    end
  end

  assign isi       = r_isi;
  assign isi_valid = r_isi_valid;
`else
  assign isi       = '0;
  assign isi_valid = 1'b0;
`endif

endmodule
